// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the IFU/LSU memory port arbiter.
// Holds the FSM state encoding, the owner tags and the write-strobe expansion.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RSP  = 2'd2
   } state_e;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   // Each strobe bit covers one byte lane of the 64-bit word.
   function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
      logic [63:0] mask;
      for (int i = 0; i < 8; i++) begin
         mask[i*8 +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Grant logic for the memory port: LSU has fixed priority, and IFU is forced in
// once it has waited through STARVE_LIMIT consecutive LSU grants.
module mem_arb_grant #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic grant_en,
   input  logic ifu_valid,
   input  logic lsu_valid,
   output logic grant_ifu,
   output logic grant_lsu
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve_cnt_q;
   logic [CW-1:0] starve_cnt_d;
   logic          ifu_forced;

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      ifu_forced   = (starve_cnt_q == CW'(STARVE_LIMIT));
      grant_lsu    = grant_en & lsu_valid & ~(ifu_valid & ifu_forced);
      grant_ifu    = grant_en & ifu_valid & ~grant_lsu;
      starve_cnt_d = starve_cnt_q;

      if (grant_ifu) begin
         starve_cnt_d = '0;
      end else if (grant_lsu) begin
         if (!ifu_valid) begin
            starve_cnt_d = '0;
         end else if (!ifu_forced) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between IFU and LSU with a single outstanding transaction.
// Commands and responses are registered so no combinational RAM-to-CPU path exists.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW           = 64,
   parameter int DW           = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ifu_req_valid,
   output logic          ifu_req_ready,
   input  logic [AW-1:0] ifu_addr,
   output logic          ifu_rsp_valid,
   output logic [DW-1:0] ifu_rsp_data,
   input  logic          lsu_req_valid,
   output logic          lsu_req_ready,
   input  logic [AW-1:0] lsu_addr,
   input  logic          lsu_wen,
   input  logic [7:0]    lsu_wstrb,
   input  logic [DW-1:0] lsu_wdata,
   output logic          lsu_rsp_valid,
   output logic [DW-1:0] lsu_rsp_data,
   output logic          ram_req_valid,
   input  logic          ram_req_ready,
   output logic [AW-1:0] ram_addr,
   output logic          ram_wen,
   output logic [DW-1:0] ram_wmask,
   output logic [DW-1:0] ram_wdata,
   input  logic          ram_rsp_valid,
   input  logic [DW-1:0] ram_rsp_data
);

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wen_q, wen_d;
   logic [DW-1:0] wmask_q, wmask_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          ifu_rsp_valid_q, ifu_rsp_valid_d;
   logic [DW-1:0] ifu_rsp_data_q, ifu_rsp_data_d;
   logic          lsu_rsp_valid_q, lsu_rsp_valid_d;
   logic [DW-1:0] lsu_rsp_data_q, lsu_rsp_data_d;
   logic          grant_ifu, grant_lsu;

   mem_arb_grant #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_grant (
      .clk       (clk),
      .rst       (rst),
      .grant_en  (state_q == IDLE),
      .ifu_valid (ifu_req_valid),
      .lsu_valid (lsu_req_valid),
      .grant_ifu (grant_ifu),
      .grant_lsu (grant_lsu)
   );

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      addr_d          = addr_q;
      wen_d           = wen_q;
      wmask_d         = wmask_q;
      wdata_d         = wdata_q;
      ifu_rsp_valid_d = 1'b0;
      ifu_rsp_data_d  = ifu_rsp_data_q;
      lsu_rsp_valid_d = 1'b0;
      lsu_rsp_data_d  = lsu_rsp_data_q;

      case (state_q)
         IDLE: begin
            if (grant_ifu || grant_lsu) begin
               // IFU commands are always plain reads with an empty mask.
               owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
               addr_d  = grant_lsu ? lsu_addr : ifu_addr;
               wen_d   = grant_lsu & lsu_wen;
               wmask_d = grant_lsu ? DW'(strb_to_mask(lsu_wstrb)) : '0;
               wdata_d = grant_lsu ? lsu_wdata : '0;
               state_d = CMD;
            end
         end
         CMD: begin
            if (ram_req_ready) state_d = RSP;
         end
         RSP: begin
            if (ram_rsp_valid) begin
               state_d = IDLE;
               if (owner_q == OWN_LSU) begin
                  lsu_rsp_valid_d = 1'b1;
                  lsu_rsp_data_d  = wen_q ? '0 : ram_rsp_data;
               end else begin
                  ifu_rsp_valid_d = 1'b1;
                  ifu_rsp_data_d  = ram_rsp_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         owner_q         <= OWN_IFU;
         addr_q          <= '0;
         wen_q           <= 1'b0;
         wmask_q         <= '0;
         wdata_q         <= '0;
         ifu_rsp_valid_q <= 1'b0;
         ifu_rsp_data_q  <= '0;
         lsu_rsp_valid_q <= 1'b0;
         lsu_rsp_data_q  <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         addr_q          <= addr_d;
         wen_q           <= wen_d;
         wmask_q         <= wmask_d;
         wdata_q         <= wdata_d;
         ifu_rsp_valid_q <= ifu_rsp_valid_d;
         ifu_rsp_data_q  <= ifu_rsp_data_d;
         lsu_rsp_valid_q <= lsu_rsp_valid_d;
         lsu_rsp_data_q  <= lsu_rsp_data_d;
      end
   end

   assign ifu_req_ready = grant_ifu;
   assign lsu_req_ready = grant_lsu;
   assign ram_req_valid = (state_q == CMD);
   assign ram_addr      = addr_q;
   assign ram_wen       = wen_q;
   assign ram_wmask     = wmask_q;
   assign ram_wdata     = wdata_q;
   assign ifu_rsp_valid = ifu_rsp_valid_q;
   assign ifu_rsp_data  = ifu_rsp_data_q;
   assign lsu_rsp_valid = lsu_rsp_valid_q;
   assign lsu_rsp_data  = lsu_rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter: single transactions, arbitration
// order with starvation guard, command stall and reset mid-transaction.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready;
   logic [63:0] ifu_addr;
   logic        ifu_rsp_valid;
   logic [63:0] ifu_rsp_data;
   logic        lsu_req_valid, lsu_req_ready;
   logic [63:0] lsu_addr;
   logic        lsu_wen;
   logic [7:0]  lsu_wstrb;
   logic [63:0] lsu_wdata;
   logic        lsu_rsp_valid;
   logic [63:0] lsu_rsp_data;
   logic        ram_req_valid, ram_req_ready;
   logic [63:0] ram_addr;
   logic        ram_wen;
   logic [63:0] ram_wmask, ram_wdata;
   logic        ram_rsp_valid;
   logic [63:0] ram_rsp_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW(64), .DW(64), .STARVE_LIMIT(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_addr      (ifu_addr),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_data  (ifu_rsp_data),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_addr      (lsu_addr),
      .lsu_wen       (lsu_wen),
      .lsu_wstrb     (lsu_wstrb),
      .lsu_wdata     (lsu_wdata),
      .lsu_rsp_valid (lsu_rsp_valid),
      .lsu_rsp_data  (lsu_rsp_data),
      .ram_req_valid (ram_req_valid),
      .ram_req_ready (ram_req_ready),
      .ram_addr      (ram_addr),
      .ram_wen       (ram_wen),
      .ram_wmask     (ram_wmask),
      .ram_wdata     (ram_wdata),
      .ram_rsp_valid (ram_rsp_valid),
      .ram_rsp_data  (ram_rsp_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ram_req_valid"}, {63'd0, ram_req_valid}, 64'd0);
      check({tag, "_ram_addr"},      ram_addr,               64'd0);
      check({tag, "_ram_wen"},       {63'd0, ram_wen},       64'd0);
      check({tag, "_ram_wmask"},     ram_wmask,              64'd0);
      check({tag, "_ram_wdata"},     ram_wdata,              64'd0);
      check({tag, "_ifu_rsp_valid"}, {63'd0, ifu_rsp_valid}, 64'd0);
      check({tag, "_ifu_rsp_data"},  ifu_rsp_data,           64'd0);
      check({tag, "_lsu_rsp_valid"}, {63'd0, lsu_rsp_valid}, 64'd0);
      check({tag, "_lsu_rsp_data"},  lsu_rsp_data,           64'd0);
      check({tag, "_readies"},       {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
   endtask

   // Expected grant per transaction with both requesters valid: 1 = LSU, 0 = IFU.
   logic [11:0] exp_lsu_first = 12'b1111_0111_1011;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = '0;
      lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wstrb = '0; lsu_wdata = '0;
      ram_req_ready = 1'b0; ram_rsp_valid = 1'b0; ram_rsp_data = '0;
      step();
      step();
      check_all_zero("reset");
      rst = 1'b0;
      step();

      // Test 1: IFU read, minimum latency
      ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
      #1;
      check("t1_ifu_ready", {63'd0, ifu_req_ready}, 64'd1);
      check("t1_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
      step();                                   // N+1
      ifu_req_valid = 1'b0;
      check("t1_ram_valid", {63'd0, ram_req_valid}, 64'd1);
      check("t1_ram_addr",  ram_addr, 64'h8000_0000);
      check("t1_ram_wen",   {63'd0, ram_wen}, 64'd0);
      check("t1_ram_wmask", ram_wmask, 64'd0);
      ram_req_ready = 1'b1;
      step();                                   // N+2
      ram_req_ready = 1'b0;
      check("t1_ram_valid_drop", {63'd0, ram_req_valid}, 64'd0);
      ram_rsp_valid = 1'b1; ram_rsp_data = 64'h1122_3344_5566_7788;
      step();                                   // N+3
      ram_rsp_valid = 1'b0;
      check("t1_ifu_rsp_valid", {63'd0, ifu_rsp_valid}, 64'd1);
      check("t1_ifu_rsp_data",  ifu_rsp_data, 64'h1122_3344_5566_7788);
      check("t1_lsu_rsp_valid", {63'd0, lsu_rsp_valid}, 64'd0);
      step();
      check("t1_ifu_rsp_pulse", {63'd0, ifu_rsp_valid}, 64'd0);
      check("t1_ifu_rsp_hold",  ifu_rsp_data, 64'h1122_3344_5566_7788);

      // Test 2: LSU write with partial strobe
      lsu_req_valid = 1'b1; lsu_addr = 64'h8000_0008; lsu_wen = 1'b1;
      lsu_wstrb = 8'h0F; lsu_wdata = 64'hDEAD_BEEF;
      #1;
      check("t2_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
      step();
      lsu_req_valid = 1'b0;
      check("t2_ram_valid", {63'd0, ram_req_valid}, 64'd1);
      check("t2_ram_addr",  ram_addr, 64'h8000_0008);
      check("t2_ram_wen",   {63'd0, ram_wen}, 64'd1);
      check("t2_ram_wmask", ram_wmask, 64'h0000_0000_FFFF_FFFF);
      check("t2_ram_wdata", ram_wdata, 64'hDEAD_BEEF);
      ram_req_ready = 1'b1;
      step();
      ram_req_ready = 1'b0;
      ram_rsp_valid = 1'b1; ram_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      ram_rsp_valid = 1'b0;
      check("t2_lsu_rsp_valid", {63'd0, lsu_rsp_valid}, 64'd1);
      check("t2_lsu_rsp_data",  lsu_rsp_data, 64'd0);
      check("t2_ifu_rsp_valid", {63'd0, ifu_rsp_valid}, 64'd0);
      check("t2_ifu_rsp_hold",  ifu_rsp_data, 64'h1122_3344_5566_7788);
      step();
      check("t2_lsu_rsp_pulse", {63'd0, lsu_rsp_valid}, 64'd0);

      // Tests 3 and 4: both valid, LSU priority with starvation guard
      lsu_req_valid = 1'b1; lsu_addr = 64'h8000_0100; lsu_wen = 1'b0; lsu_wstrb = 8'h00;
      ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0200;
      #1;
      check("t3_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
      check("t3_ifu_ready", {63'd0, ifu_req_ready}, 64'd0);
      for (int t = 0; t < 12; t++) begin
         logic exp_l;
         exp_l = exp_lsu_first[11 - t];
         check($sformatf("t4_grant%0d", t), {62'd0, ifu_req_ready, lsu_req_ready},
               exp_l ? 64'd1 : 64'd2);
         check($sformatf("t4_addr%0d_pre", t), {63'd0, ram_req_valid}, 64'd0);
         step();
         check($sformatf("t4_addr%0d", t), ram_addr,
               exp_l ? 64'h8000_0100 : 64'h8000_0200);
         ram_req_ready = 1'b1;
         step();
         ram_req_ready = 1'b0;
         ram_rsp_valid = 1'b1; ram_rsp_data = 64'h5555_0000 + 64'(t);
         step();
         ram_rsp_valid = 1'b0;
         check($sformatf("t4_rsp%0d", t), {62'd0, ifu_rsp_valid, lsu_rsp_valid},
               exp_l ? 64'd1 : 64'd2);
         check($sformatf("t4_data%0d", t), exp_l ? lsu_rsp_data : ifu_rsp_data,
               64'h5555_0000 + 64'(t));
         #1;
      end
      lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
      step();

      // Test 5: RAM stalls the command; stray response during CMD is ignored
      lsu_req_valid = 1'b1; lsu_addr = 64'h8000_0010; lsu_wen = 1'b1;
      lsu_wstrb = 8'hF0; lsu_wdata = 64'h0123_4567_89AB_CDEF;
      #1;
      check("t5_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
      step();
      lsu_req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t5_valid%0d", k), {63'd0, ram_req_valid}, 64'd1);
         check($sformatf("t5_addr%0d", k),  ram_addr,  64'h8000_0010);
         check($sformatf("t5_wdata%0d", k), ram_wdata, 64'h0123_4567_89AB_CDEF);
         check($sformatf("t5_wmask%0d", k), ram_wmask, 64'hFFFF_FFFF_0000_0000);
         ram_rsp_valid = (k == 1);
         ram_rsp_data  = 64'hBAD0_BAD0;
         step();
         ram_rsp_valid = 1'b0;
      end
      check("t5_valid_held", {63'd0, ram_req_valid}, 64'd1);
      check("t5_no_early_rsp", {63'd0, lsu_rsp_valid}, 64'd0);
      ram_req_ready = 1'b1;
      step();
      ram_req_ready = 1'b0;
      check("t5_ram_valid_drop", {63'd0, ram_req_valid}, 64'd0);
      ram_rsp_valid = 1'b1; ram_rsp_data = 64'hAAAA_AAAA;
      step();
      ram_rsp_valid = 1'b0;
      check("t5_lsu_rsp_valid", {63'd0, lsu_rsp_valid}, 64'd1);
      check("t5_lsu_rsp_data",  lsu_rsp_data, 64'd0);
      step();

      // Test 6: reset while waiting for the response drops the transaction
      ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0040;
      #1;
      check("t6_ifu_ready", {63'd0, ifu_req_ready}, 64'd1);
      step();
      ifu_req_valid = 1'b0;
      ram_req_ready = 1'b1;
      step();
      ram_req_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_all_zero("t6_reset");
      ram_rsp_valid = 1'b1; ram_rsp_data = 64'hCCCC_CCCC;
      step();
      ram_rsp_valid = 1'b0;
      check("t6_late_ifu_rsp", {63'd0, ifu_rsp_valid}, 64'd0);
      check("t6_late_lsu_rsp", {63'd0, lsu_rsp_valid}, 64'd0);
      check("t6_late_ifu_data", ifu_rsp_data, 64'd0);
      check("t6_ram_idle",      {63'd0, ram_req_valid}, 64'd0);
      ifu_req_valid = 1'b1;
      #1;
      check("t6_idle_grant", {63'd0, ifu_req_ready}, 64'd1);
      ifu_req_valid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
